// File: rtl/rvvi_depacketizer.sv
// RVVI depacketizer: filters MAC/EtherType on a 32-bit AXI-stream RX feed, reassembles
// one RVVI record per good frame and hands it out on a valid/ready port.
package rvvi_depacketizer_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;
endpackage

module rvvi_depacketizer
  import rvvi_depacketizer_pkg::*;
#(
  parameter cvw_t P          = '{XLEN: 64},
  parameter int   MAX_CSRS   = 5,
  localparam int  RVVI_WIDTH = 72 + 5*int'(P.XLEN) + MAX_CSRS*(int'(P.XLEN) + 16)
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [31:0]           RvviAxiRdata,
  input  logic [3:0]            RvviAxiRstrb,
  input  logic                  RvviAxiRlast,
  input  logic                  RvviAxiRuser,
  input  logic                  RvviAxiRvalid,
  output logic                  RvviAxiRready,
  input  logic [47:0]           DstMac,
  input  logic [47:0]           SrcMac,
  input  logic [15:0]           EthType,
  output logic                  Valid,
  output logic [RVVI_WIDTH-1:0] Rvvi,
  input  logic                  Ready,
  output logic [15:0]           GoodFrames,
  output logic [15:0]           BadFrames
);

  localparam int PAYLOAD_WORDS = (RVVI_WIDTH + 31) / 32;
  localparam int SHADOW_W      = PAYLOAD_WORDS * 32;
  localparam int CNT_W         = (PAYLOAD_WORDS > 4) ? $clog2(PAYLOAD_WORDS) : 2;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {HDR, PAY, TAIL, DROP, OUT} stateType;

  stateType         state, nextState;
  logic [CNT_W-1:0] beatCnt, nextCnt;
  logic [31:0]      shadow [PAYLOAD_WORDS];
  logic [SHADOW_W-1:0] loadData;
  logic             beatFire, fullKeep, hdrMatch;
  logic             shadowWe, loadRvvi, goodInc, badInc;
  logic [127:0]     hdrPadded;
  logic [31:0]      hdrChunk, hdrExpect, hdrMask;

  assign beatFire = RvviAxiRvalid & RvviAxiRready;
  assign fullKeep = (RvviAxiRstrb == 4'hF);

  // Header bytes go out MSB-first, but byte 0 of each beat sits on [7:0], hence the swap.
  assign hdrPadded = {DstMac, SrcMac, EthType, 16'h0000};
  assign hdrChunk  = hdrPadded[32*(3 - int'(beatCnt[1:0])) +: 32];
  assign hdrExpect = {hdrChunk[7:0], hdrChunk[15:8], hdrChunk[23:16], hdrChunk[31:24]};
  assign hdrMask   = (beatCnt[1:0] == 2'd3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign hdrMatch  = (((RvviAxiRdata ^ hdrExpect) & hdrMask) == 32'h0);

  assign RvviAxiRready = (state != OUT);
  assign Valid         = (state == OUT);

  // The final payload word may arrive on the same beat as tlast, so bypass it into the record.
  always_comb begin
    for (int k = 0; k < PAYLOAD_WORDS; k++) begin
      loadData[32*k +: 32] = shadow[k];
    end
    if (state == PAY) begin
      loadData[SHADOW_W-1 -: 32] = RvviAxiRdata;
    end
  end

  generate
    if (SHADOW_W > RVVI_WIDTH) begin : g_pad
      logic unusedPadBits;
      assign unusedPadBits = ^loadData[SHADOW_W-1:RVVI_WIDTH];
    end
  endgenerate

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    nextCnt   = beatCnt;
    shadowWe  = 1'b0;
    loadRvvi  = 1'b0;
    goodInc   = 1'b0;
    badInc    = 1'b0;
    case (state)
      HDR: if (beatFire) begin
        if (!hdrMatch || !fullKeep || RvviAxiRlast) begin
          nextCnt = '0;
          if (RvviAxiRlast) begin
            badInc    = 1'b1;
            nextState = HDR;
          end else begin
            nextState = DROP;
          end
        end else if (beatCnt[1:0] == 2'd3) begin
          nextCnt   = '0;
          nextState = PAY;
        end else begin
          nextCnt = beatCnt + CNT_W'(1);
        end
      end
      PAY: if (beatFire) begin
        shadowWe = 1'b1;
        nextCnt  = '0;
        if (beatCnt == LAST_WORD) begin
          if (!RvviAxiRlast) begin
            nextState = TAIL;
          end else if (RvviAxiRuser) begin
            badInc    = 1'b1;
            nextState = HDR;
          end else begin
            loadRvvi  = 1'b1;
            goodInc   = 1'b1;
            nextState = OUT;
          end
        end else if (RvviAxiRlast) begin
          badInc    = 1'b1;
          nextState = HDR;
        end else if (!fullKeep) begin
          // Counted once, when the rest of the frame drains through DROP.
          nextState = DROP;
        end else begin
          nextCnt = beatCnt + CNT_W'(1);
        end
      end
      TAIL: if (beatFire && RvviAxiRlast) begin
        if (RvviAxiRuser) begin
          badInc    = 1'b1;
          nextState = HDR;
        end else begin
          loadRvvi  = 1'b1;
          goodInc   = 1'b1;
          nextState = OUT;
        end
      end
      DROP: if (beatFire && RvviAxiRlast) begin
        badInc    = 1'b1;
        nextState = HDR;
      end
      OUT: if (Ready) nextState = HDR;
      default: nextState = HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state      <= HDR;
      beatCnt    <= '0;
      Rvvi       <= '0;
      GoodFrames <= 16'h0;
      BadFrames  <= 16'h0;
    end else begin
      state   <= nextState;
      beatCnt <= nextCnt;
      if (loadRvvi) Rvvi <= loadData[RVVI_WIDTH-1:0];
      if (goodInc)  GoodFrames <= GoodFrames + 16'd1;
      if (badInc)   BadFrames  <= BadFrames + 16'd1;
    end
  end

  // NOTE: the shadow store is data-only and always fully rewritten before use, so it carries no reset.
  always_ff @(posedge s_axi_aclk) begin
    if (shadowWe) shadow[beatCnt] <= RvviAxiRdata;
  end

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer at XLEN=64, MAX_CSRS=3 (632-bit record, 20 payload words).
module tb_rvvi_depacketizer;
  import rvvi_depacketizer_pkg::*;

  localparam cvw_t TB_P   = '{XLEN: 64};
  localparam int   RW     = 632;
  localparam int   PW     = 20;
  localparam logic [47:0] DST    = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC    = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [15:0] ETH_OK = 16'h005c;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   RvviAxiRdata = '0;
  logic [3:0]    RvviAxiRstrb = 4'hF;
  logic          RvviAxiRlast = 1'b0;
  logic          RvviAxiRuser = 1'b0;
  logic          RvviAxiRvalid = 1'b0;
  logic          RvviAxiRready;
  logic          Valid;
  logic [RW-1:0] Rvvi;
  logic          Ready = 1'b0;
  logic [15:0]   GoodFrames, BadFrames;

  int   total = 0;
  int   bad = 0;
  logic validSeen;
  int   stallCycles;

  always #5 clk = ~clk;

  rvvi_depacketizer #(.P(TB_P), .MAX_CSRS(3)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .RvviAxiRdata(RvviAxiRdata), .RvviAxiRstrb(RvviAxiRstrb), .RvviAxiRlast(RvviAxiRlast),
    .RvviAxiRuser(RvviAxiRuser), .RvviAxiRvalid(RvviAxiRvalid), .RvviAxiRready(RvviAxiRready),
    .DstMac(DST), .SrcMac(SRC), .EthType(ETH_OK),
    .Valid(Valid), .Rvvi(Rvvi), .Ready(Ready),
    .GoodFrames(GoodFrames), .BadFrames(BadFrames)
  );

  function automatic logic [RW-1:0] exp_rvvi(input logic [31:0] base);
    logic [PW*32-1:0] full;
    for (int k = 0; k < PW; k++) full[32*k +: 32] = base + 32'(k);
    return full[RW-1:0];
  endfunction

  function automatic logic [31:0] frame_word(input int b, input logic [15:0] eth, input logic [31:0] base);
    case (b)
      0: return {DST[23:16], DST[31:24], DST[39:32], DST[47:40]};
      1: return {SRC[39:32], SRC[47:40], DST[7:0], DST[15:8]};
      2: return {SRC[7:0], SRC[15:8], SRC[23:16], SRC[31:24]};
      3: return {16'h0000, eth[7:0], eth[15:8]};
      default: return (b < 4 + PW) ? base + 32'(b - 4) : 32'hDEAD_0000 + 32'(b);
    endcase
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last, input logic user);
    int waits = 0;
    @(negedge clk);
    RvviAxiRdata = d; RvviAxiRlast = last; RvviAxiRuser = user; RvviAxiRvalid = 1'b1;
    if (Valid) validSeen = 1'b1;
    while (!RvviAxiRready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    stallCycles += waits;
    if (!RvviAxiRready) begin
      total++; bad++;
      $display("FAIL beat_accept: RvviAxiRready=%b after %0d cycles, required 1", RvviAxiRready, waits);
    end
    @(posedge clk);
    #1;
    RvviAxiRvalid = 1'b0; RvviAxiRlast = 1'b0; RvviAxiRuser = 1'b0;
  endtask

  // Sends beats firstB..stopB (stopB<0: up to tlast); lastAt<0 puts tlast on the natural final beat.
  task automatic send_frame(input logic [15:0] eth, input logic [31:0] base, input int nPad,
                            input int lastAt, input logic user, input int firstB, input int stopB);
    int tl   = (lastAt >= 0) ? lastAt : 4 + PW + nPad - 1;
    int endB = (stopB >= 0) ? stopB : tl;
    validSeen = 1'b0;
    stallCycles = 0;
    for (int b = firstB; b <= endB; b++) send_beat(frame_word(b, eth, base), b == tl, (b == tl) && user);
  endtask

  task automatic consume();
    @(negedge clk);
    Ready = 1'b1;
    @(posedge clk);
    #1;
    Ready = 1'b0;
    total++;
    if (Valid !== 1'b0) begin bad++; $display("FAIL consume_valid_drop: got %b want 0", Valid); end
  endtask

  task automatic test_reset();
    #22 rst_n = 1'b1;
    @(negedge clk);
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Valid); end
    total++; if (Rvvi !== '0) begin bad++; $display("FAIL reset_rvvi: got %h want 0", Rvvi); end
    total++; if (GoodFrames !== 16'd0) begin bad++; $display("FAIL reset_good: got %0d want 0", GoodFrames); end
    total++; if (BadFrames !== 16'd0) begin bad++; $display("FAIL reset_bad: got %0d want 0", BadFrames); end
    total++; if (RvviAxiRready !== 1'b1) begin bad++; $display("FAIL reset_rready: got %b want 1", RvviAxiRready); end
  endtask

  task automatic test_good_frame();
    send_frame(ETH_OK, 32'h1000_0000, 0, -1, 1'b0, 0, -1);
    total++; if (validSeen !== 1'b0) begin bad++; $display("FAIL good_early_valid: got %b want 0", validSeen); end
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL good_valid_latency: got %b want 1", Valid); end
    total++; if (Rvvi[31:0] !== 32'h1000_0000) begin bad++; $display("FAIL good_word0: got %h want 10000000", Rvvi[31:0]); end
    total++; if (Rvvi[631:608] !== 24'h00_0013) begin bad++; $display("FAIL good_top: got %h want 000013", Rvvi[631:608]); end
    total++; if (Rvvi !== exp_rvvi(32'h1000_0000)) begin bad++; $display("FAIL good_record: got %h want %h", Rvvi[127:0], exp_rvvi(32'h1000_0000) & 632'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF); end
    total++; if (GoodFrames !== 16'd1) begin bad++; $display("FAIL good_count: got %0d want 1", GoodFrames); end
    total++; if (stallCycles !== 0) begin bad++; $display("FAIL good_stall: got %0d want 0", stallCycles); end
    consume();
  endtask

  task automatic test_padding();
    send_frame(ETH_OK, 32'h1000_0000, 6, -1, 1'b0, 0, -1);
    total++; if (validSeen !== 1'b0) begin bad++; $display("FAIL pad_early_valid: got %b want 0", validSeen); end
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL pad_valid: got %b want 1", Valid); end
    total++; if (Rvvi !== exp_rvvi(32'h1000_0000)) begin bad++; $display("FAIL pad_record: got low word %h want 10000000", Rvvi[31:0]); end
    total++; if (BadFrames !== 16'd0) begin bad++; $display("FAIL pad_bad: got %0d want 0", BadFrames); end
    total++; if (GoodFrames !== 16'd2) begin bad++; $display("FAIL pad_good: got %0d want 2", GoodFrames); end
    consume();
  endtask

  task automatic test_bad_ethtype();
    send_frame(16'h0800, 32'h2000_0000, 0, -1, 1'b0, 0, -1);
    repeat (3) @(negedge clk);
    total++; if (stallCycles !== 0) begin bad++; $display("FAIL eth_stall: got %0d want 0", stallCycles); end
    total++; if ((Valid | validSeen) !== 1'b0) begin bad++; $display("FAIL eth_valid: got %b want 0", Valid | validSeen); end
    total++; if (BadFrames !== 16'd1) begin bad++; $display("FAIL eth_bad: got %0d want 1", BadFrames); end
    total++; if (Rvvi !== exp_rvvi(32'h1000_0000)) begin bad++; $display("FAIL eth_rvvi_kept: got low word %h want 10000000", Rvvi[31:0]); end
  endtask

  task automatic test_short_and_user();
    send_frame(ETH_OK, 32'h5000_0000, 0, 10, 1'b0, 0, -1);
    total++; if (BadFrames !== 16'd2) begin bad++; $display("FAIL short_bad: got %0d want 2", BadFrames); end
    send_frame(ETH_OK, 32'h6000_0000, 0, -1, 1'b1, 0, -1);
    repeat (2) @(negedge clk);
    total++; if (BadFrames !== 16'd3) begin bad++; $display("FAIL user_bad: got %0d want 3", BadFrames); end
    total++; if ((Valid | validSeen) !== 1'b0) begin bad++; $display("FAIL user_valid: got %b want 0", Valid | validSeen); end
    total++; if (Rvvi !== exp_rvvi(32'h1000_0000)) begin bad++; $display("FAIL user_rvvi_kept: got low word %h want 10000000", Rvvi[31:0]); end
    total++; if (GoodFrames !== 16'd2) begin bad++; $display("FAIL user_good: got %0d want 2", GoodFrames); end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] expA = exp_rvvi(32'h3000_0000);
    logic [RW-1:0] expB = exp_rvvi(32'h4000_0000);
    int holdBad = 0;
    int n = 0;
    send_frame(ETH_OK, 32'h3000_0000, 0, -1, 1'b0, 0, -1);
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b want 1", Valid); end
    fork
      send_frame(ETH_OK, 32'h4000_0000, 0, -1, 1'b0, 0, -1);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (RvviAxiRready !== 1'b0 || Valid !== 1'b1 || Rvvi !== expA) holdBad++;
        end
        total++; if (holdBad !== 0) begin bad++; $display("FAIL bp_hold: %0d stalled cycles wrong, want 0", holdBad); end
        @(negedge clk);
        Ready = 1'b1;
        @(posedge clk);
        #1;
        Ready = 1'b0;
        // Release cycle plus the 24 beats of the queued frame.
        n = 1;
        while (!Valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        total++; if (n !== 25) begin bad++; $display("FAIL bp_spacing: got %0d cycles want 25", n); end
      end
    join
    total++; if (Rvvi !== expB) begin bad++; $display("FAIL bp_second_record: got low word %h want 40000000", Rvvi[31:0]); end
    total++; if (GoodFrames !== 16'd4) begin bad++; $display("FAIL bp_good: got %0d want 4", GoodFrames); end
    consume();
  endtask

  task automatic test_reset_midframe();
    send_frame(ETH_OK, 32'h7000_0000, 0, -1, 1'b0, 0, 11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", Valid); end
    total++; if ({GoodFrames, BadFrames} !== 32'h0) begin bad++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", GoodFrames, BadFrames); end
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(ETH_OK, 32'h7000_0000, 0, -1, 1'b0, 12, -1);
    total++; if (BadFrames !== 16'd1) begin bad++; $display("FAIL rstmid_bad: got %0d want 1", BadFrames); end
    total++; if ((Valid | validSeen) !== 1'b0) begin bad++; $display("FAIL rstmid_tail_valid: got %b want 0", Valid | validSeen); end
    send_frame(ETH_OK, 32'h8000_0000, 0, -1, 1'b0, 0, -1);
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL rstmid_clean_valid: got %b want 1", Valid); end
    total++; if (GoodFrames !== 16'd1) begin bad++; $display("FAIL rstmid_good: got %0d want 1", GoodFrames); end
    total++; if (Rvvi !== exp_rvvi(32'h8000_0000)) begin bad++; $display("FAIL rstmid_record: got low word %h want 80000000", Rvvi[31:0]); end
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_padding();
    test_bad_ethtype();
    test_short_and_user();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvvi_depacketizer.md
Name: rvvi_depacketizer

Overview:
- Receive-side counterpart of the RVVI packetizer.
- Consumes 32-bit AXI-stream beats from the Ethernet MAC RX FIFO and filters on destination MAC, source MAC and EtherType.
- Reassembles the RVVI record and presents it on a valid/ready interface.
- Used on the host/checker FPGA and in loopback benches to recover the trace stream; good and bad frames are counted for link diagnostics.

Parameters:
- P, cvw_t, core configuration (uses P.XLEN).
- MAX_CSRS, 5, CSR slots per record. Local RVVI_WIDTH = 72+5*P.XLEN+MAX_CSRS*(P.XLEN+16). Local PAYLOAD_WORDS = ceil(RVVI_WIDTH/32).

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  reset.
- RvviAxiRdata  in  32  stream data; byte 0 on [7:0].
- RvviAxiRstrb  in  4  byte keep.
- RvviAxiRlast  in  1  last beat of frame.
- RvviAxiRuser  in  1  MAC error flag, meaningful on the last beat.
- RvviAxiRvalid  in  1  beat valid.
- RvviAxiRready  out  1  beat accept.
- DstMac  in  48  expected destination MAC.
- SrcMac  in  48  expected source MAC.
- EthType  in  16  expected EtherType.
- Valid  out  1  record available.
- Rvvi  out  RVVI_WIDTH  record.
- Ready  in  1  consumer accepts record.
- GoodFrames  out  16  accepted-frame count, wraps.
- BadFrames  out  16  dropped-frame count, wraps.

Interface decision (fixed): one clock, s_axi_aclk; reset s_axi_aresetn is asynchronous and active-low.

Behaviour:
- Reset (asynchronous, active-low): state HDR, beat counter 0, Valid=0, Rvvi=0, GoodFrames=0, BadFrames=0. RvviAxiRready=1 the first cycle after release.
- Beat transfer: occurs when RvviAxiRvalid & RvviAxiRready on a rising edge.
- Frame layout, in beats:
  - Beats 0-3 are the header: DstMac bytes 47:40 first, then SrcMac, then EthType high byte first, then 2 reserved bytes (ignored).
  - Beats 4..4+PAYLOAD_WORDS-1 are payload; beat 4+k carries Rvvi[32k+31:32k]. Bits above RVVI_WIDTH are ignored.
  - Any further beats up to tlast are padding and are discarded.
- State HDR: RvviAxiRready=1; header bytes are compared against the inputs beat by beat.
  - Any mismatch, keep!=4'hF, or tlast during the header -> DROP (or straight to HDR if that beat had tlast).
  - After beat 3 matches -> PAY.
- State PAY: RvviAxiRready=1; payload words are written into the shadow register.
  - tlast before the final payload word, or keep!=4'hF on a non-final payload beat -> bad frame, return to HDR.
  - Final payload word without tlast -> TAIL.
  - Final payload word with tlast -> check user (see TAIL).
- State TAIL: RvviAxiRready=1; beats are discarded until tlast.
  - On tlast with RvviAxiRuser=0: the shadow register is copied to Rvvi, Valid=1 next cycle, GoodFrames+1, -> OUT.
  - On tlast with RvviAxiRuser=1: BadFrames+1, -> HDR, Valid stays 0.
- State DROP: RvviAxiRready=1; beats are discarded until tlast; then BadFrames+1 and -> HDR.
- State OUT: RvviAxiRready=0, Valid=1, Rvvi held stable.
  - On Ready=1, Valid drops next cycle -> HDR.
  - Back-pressure stalls the MAC RX FIFO; no frame is ever silently overwritten.
- Latency: Valid asserts exactly 1 cycle after the tlast handshake of a good frame. Minimum record-to-record spacing is frame beats + 1 cycle.
- Counters increment once per frame at tlast; both wrap 16'hFFFF -> 0.
- Bad-frame accounting: a header mismatch and a short frame each count exactly once. A bad frame whose tlast arrives in HDR/PAY counts on that beat.
- Rvvi is written only on good frames, so a dropped frame never alters a record already presented.
- Reset asserted mid-frame returns to HDR immediately. The remaining beats of that frame are parsed as a header; they mismatch and are dropped via DROP (counted once in BadFrames).
- RvviAxiRvalid low mid-frame pauses the FSM with no timeout.

Test Plan:
- XLEN=64, MAX_CSRS=3 (RVVI_WIDTH=632, 20 payload words): send one 24-beat frame with matching header, payload word k = 32'h1000_0000+k, tlast on beat 23, user=0, Ready=1 -> Valid high 1 cycle after the tlast handshake, Rvvi[31:0]=32'h1000_0000, Rvvi[631:608]=24'h00_0013 (low 24 bits of word 19), GoodFrames=1.
- Same frame with 6 padding beats after the payload -> identical Rvvi; Valid 1 cycle after the beat-29 tlast; BadFrames=0.
- EtherType 16'h0800 instead of 16'h005c -> no Valid; all 24 beats accepted; BadFrames=1.
- tlast on beat 10, then user=1 on a full frame -> BadFrames=2, Rvvi unchanged from the prior good record, Valid never asserts.
- Ready held 0 for 50 cycles with a second frame queued -> RvviAxiRready=0 throughout and Rvvi stable. Ready=1 then yields the first record; the second record is valid 25+ cycles later; GoodFrames=2.
- Reset pulsed at beat 12 of a frame -> Valid=0 and counters=0. Remaining beats drop with BadFrames=1; the next clean frame gives GoodFrames=1.
